// File: rtl/serial_scan_display_pkg.sv
// Shared constants for the serial scan display: segment table, special codes, FSM encodings.
package serial_scan_display_pkg;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'h40;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [1:0] CIDLE  = 2'd0;
   localparam logic [1:0] CSHIFT = 2'd1;
   localparam logic [1:0] CDONE  = 2'd2;

   // Hex digit to active-high a..g pattern, dp clear.
   function automatic logic [7:0] seg_code(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'h0: s = 8'h3F;
         4'h1: s = 8'h06;
         4'h2: s = 8'h5B;
         4'h3: s = 8'h4F;
         4'h4: s = 8'h66;
         4'h5: s = 8'h6D;
         4'h6: s = 8'h7D;
         4'h7: s = 8'h07;
         4'h8: s = 8'h7F;
         4'h9: s = 8'h6F;
         4'hA: s = 8'h77;
         4'hB: s = 8'h7C;
         4'hC: s = 8'h39;
         4'hD: s = 8'h5E;
         4'hE: s = 8'h79;
         default: s = 8'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sd_uart_rx.sv
// 8N1 UART byte receiver with input synchroniser; flags good bytes and bad stop bits.
module sd_uart_rx
   import serial_scan_display_pkg::*;
#(
   parameter int unsigned BIT_DIV = 16
)(
   input  logic       clk1M8,
   input  logic       rst_n,
   input  logic       serial,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       stop_err,
   output logic       busy_c
);

   localparam int unsigned      CNT_W     = $clog2(BIT_DIV);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);

   logic [1:0]       sync_q;
   logic             line_prev;
   logic             line;
   logic [1:0]       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [2:0]       bit_idx, bit_idx_d;
   logic [7:0]       shift_d;
   logic             byte_valid_d, stop_err_d;

   assign line   = sync_q[1];
   assign busy_c = (state != RX_IDLE);

   // Synchroniser and edge history reset to the idle-high line level.
   always_ff @(posedge clk1M8 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         line_prev <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], serial};
         line_prev <= sync_q[1];
      end
   end

   always_ff @(posedge clk1M8 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         bit_idx    <= bit_idx_d;
         rx_byte    <= shift_d;
         byte_valid <= byte_valid_d;
         stop_err   <= stop_err_d;
      end
   end

   always_comb begin
      state_d      = state;
      cnt_d        = cnt + 1'b1;
      bit_idx_d    = bit_idx;
      shift_d      = rx_byte;
      byte_valid_d = 1'b0;
      stop_err_d   = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_d = '0;
            if (line_prev && !line) state_d = RX_START;
         end
         RX_START: begin
            // A line that is high again at mid-start was a glitch.
            if (cnt == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = line ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {line, rx_byte[7:1]};
               bit_idx_d = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (line) byte_valid_d = 1'b1;
               else      stop_err_d   = 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/serial_scan_display.sv
// Receives little-endian value frames over UART, converts to hex/decimal digits and scans a
// multiplexed 7-segment display.
module serial_scan_display
   import serial_scan_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned BIT_DIV    = 16,
   parameter int unsigned SCAN_DIV   = 1800,
   parameter int unsigned GAP_CYC    = 4096,
   parameter int unsigned STALE_CYC  = 1800000
)(
   input  logic                  clk1M8,
   input  logic                  rst_n,
   input  logic                  serial,
   input  logic                  mode_dec,
   input  logic                  blank_lz,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  frame_valid,
   output logic                  frame_err
);

   localparam int unsigned FRAME_BYTES = (DATA_W + 7) / 8;
   localparam int unsigned FRAME_W     = FRAME_BYTES * 8;
   localparam int unsigned BCNT_W      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int unsigned GAP_W       = $clog2(GAP_CYC + 1);
   localparam int unsigned SCAN_W      = $clog2(SCAN_DIV + 1);
   localparam int unsigned STALE_W     = $clog2(STALE_CYC + 2);
   localparam int unsigned BCD_W       = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W       = $clog2(NUM_DIGITS);
   localparam int unsigned CCNT_W      = $clog2(DATA_W + 1);
   localparam logic [63:0] DEC_LIMIT   = 64'(10 ** NUM_DIGITS);

   logic [7:0]          rx_byte;
   logic                byte_valid, stop_err, rx_busy_c;
   logic [FRAME_W-1:0]  frame_q, frame_full_c;
   logic [BCNT_W-1:0]   bcnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic [DATA_W-1:0]   value_q;
   logic                frame_done_c, gap_to_c;

   sd_uart_rx #(.BIT_DIV(BIT_DIV)) u_rx (
      .clk1M8    (clk1M8),
      .rst_n     (rst_n),
      .serial    (serial),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .stop_err  (stop_err),
      .busy_c    (rx_busy_c)
   );

   always_comb begin
      frame_full_c                 = frame_q;
      frame_full_c[FRAME_W-1 -: 8] = rx_byte;
   end

   assign frame_done_c = byte_valid && (bcnt == BCNT_W'(FRAME_BYTES - 1));
   assign gap_to_c     = (bcnt != '0) && !rx_busy_c && (gap_cnt == GAP_W'(GAP_CYC - 1));

   // Frame assembly; any error drops the partial frame and restarts at byte 0.
   always_ff @(posedge clk1M8 or negedge rst_n) begin
      if (!rst_n) begin
         bcnt        <= '0;
         gap_cnt     <= '0;
         frame_q     <= '0;
         value_q     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= frame_done_c;
         frame_err   <= stop_err || gap_to_c;
         if (bcnt == '0 || rx_busy_c) gap_cnt <= '0;
         else                         gap_cnt <= gap_cnt + 1'b1;
         if (stop_err || gap_to_c || frame_done_c) begin
            bcnt <= '0;
         end else if (byte_valid) begin
            for (int i = 0; i < int'(FRAME_BYTES); i++)
               if (bcnt == BCNT_W'(i)) frame_q[8*i +: 8] <= rx_byte;
            bcnt <= bcnt + 1'b1;
         end
         if (frame_done_c) value_q <= frame_full_c[DATA_W-1:0];
      end
   end

   // ---------------- converter ----------------
   logic [1:0]              cstate, cstate_d;
   logic [CCNT_W-1:0]       ccnt, ccnt_d;
   logic [DATA_W-1:0]       sh_q, sh_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d, dd_bcd_c;
   logic                    dec_q, dec_d, ovf_q, ovf_d;
   logic [DATA_W+BCD_W-1:0] value_ext_c;

   assign value_ext_c = {BCD_W'(0), value_q};

   always_ff @(posedge clk1M8 or negedge rst_n) begin
      if (!rst_n) begin
         cstate <= CIDLE;
         ccnt   <= '0;
         sh_q   <= '0;
         bcd_q  <= '0;
         dec_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cstate <= cstate_d;
         ccnt   <= ccnt_d;
         sh_q   <= sh_d;
         bcd_q  <= bcd_d;
         dec_q  <= dec_d;
         ovf_q  <= ovf_d;
      end
   end

   // Double-dabble add-3 correction ahead of each shift.
   always_comb begin
      dd_bcd_c = bcd_q;
      for (int i = 0; i < int'(NUM_DIGITS); i++)
         if (bcd_q[4*i +: 4] >= 4'd5) dd_bcd_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   always_comb begin
      cstate_d = cstate;
      ccnt_d   = ccnt;
      sh_d     = sh_q;
      bcd_d    = bcd_q;
      dec_d    = dec_q;
      ovf_d    = ovf_q;
      case (cstate)
         CIDLE: ccnt_d = '0;
         CSHIFT: begin
            if (dec_q) begin
               {bcd_d, sh_d} = {dd_bcd_c[BCD_W-2:0], sh_q, 1'b0};
               ccnt_d        = ccnt + 1'b1;
               if (ccnt == CCNT_W'(DATA_W - 1)) cstate_d = CDONE;
            end else begin
               cstate_d = CDONE;
            end
         end
         CDONE:   cstate_d = CIDLE;
         default: cstate_d = CIDLE;
      endcase
      // A new frame always wins, abandoning any conversion in flight.
      if (frame_valid) begin
         cstate_d = CSHIFT;
         ccnt_d   = '0;
         sh_d     = value_q;
         dec_d    = mode_dec;
         bcd_d    = mode_dec ? '0 : value_ext_c[BCD_W-1:0];
         ovf_d    = mode_dec ? (64'(value_q) >= DEC_LIMIT)
                             : (|value_ext_c[DATA_W+BCD_W-1:BCD_W]);
      end
   end

   // ---------------- digit codes, stale blanking, scan ----------------
   logic [7:0]         code_c [NUM_DIGITS];
   logic [7:0]         disp_q [NUM_DIGITS];
   logic               lead_c;
   logic [STALE_W-1:0] stale_cnt;
   logic               stale_hit_c;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]   idx, idx_d;
   logic               scan_wrap_c;

   // Scan from the top digit down; zeros stay blank until the first nonzero digit.
   always_comb begin
      lead_c = 1'b1;
      code_c = '{default: SEG_BLANK};
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         if (ovf_q)
            code_c[i] = SEG_DASH;
         else if (dec_q && blank_lz && lead_c && bcd_q[4*i +: 4] == 4'd0 && i != 0)
            code_c[i] = SEG_BLANK;
         else
            code_c[i] = seg_code(bcd_q[4*i +: 4]);
         if (bcd_q[4*i +: 4] != 4'd0) lead_c = 1'b0;
      end
   end

   assign stale_hit_c = (STALE_CYC != 0) && (stale_cnt == STALE_W'(STALE_CYC));
   assign scan_wrap_c = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign idx_d       = !scan_wrap_c ? idx :
                        (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

   always_ff @(posedge clk1M8 or negedge rst_n) begin
      if (!rst_n) begin
         disp_q    <= '{default: SEG_BLANK};
         stale_cnt <= '0;
         scan_cnt  <= '0;
         idx       <= '0;
         dig_sel   <= NUM_DIGITS'(1);
         seg       <= SEG_BLANK;
      end else begin
         if (frame_done_c)      stale_cnt <= '0;
         else if (!stale_hit_c) stale_cnt <= stale_cnt + 1'b1;
         if (cstate == CDONE)   disp_q <= code_c;
         else if (stale_hit_c)  disp_q <= '{default: SEG_BLANK};
         scan_cnt <= scan_wrap_c ? '0 : scan_cnt + 1'b1;
         idx      <= idx_d;
         dig_sel  <= NUM_DIGITS'(1) << idx_d;
         seg      <= disp_q[idx_d];
      end
   end

endmodule

// File: tb/tb_serial_scan_display.sv
// Randomised UART frames checked every cycle against an arithmetic display model, plus literal digit checks.
`timescale 1ns/1ps
module tb_serial_scan_display;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int BD    = 16;
   localparam int SD    = 24;
   localparam int GAP   = 600;
   localparam int STALE = 6000;

   localparam logic [7:0] SEGTAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   logic         clk1M8   = 1'b0;
   logic         rst_n    = 1'b0;
   logic         serial   = 1'b1;
   logic         mode_dec = 1'b0;
   logic         blank_lz = 1'b0;
   logic [7:0]   seg;
   logic [N-1:0] dig_sel;
   logic         frame_valid, frame_err;

   serial_scan_display #(
      .NUM_DIGITS(N), .DATA_W(DW), .BIT_DIV(BD), .SCAN_DIV(SD), .GAP_CYC(GAP), .STALE_CYC(STALE)
   ) dut (
      .clk1M8     (clk1M8),
      .rst_n      (rst_n),
      .serial     (serial),
      .mode_dec   (mode_dec),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .dig_sel    (dig_sel),
      .frame_valid(frame_valid),
      .frame_err  (frame_err)
   );

   always #5 clk1M8 = ~clk1M8;

   int total = 0;
   int bad   = 0;
   int fv_cnt = 0, fe_cnt = 0, exp_fv = 0, exp_fe = 0;
   int edges = 0, pend = 0, stale_cnt = 0, exp_idx;
   logic [7:0]    exp_disp [N];
   logic [DW-1:0] sent_val = '0;
   bit            sent_dec = 0, sent_blz = 0;

   // What digit i must show for value v, straight from the display rules.
   function automatic logic [7:0] model_code(input longint unsigned v, input bit dec, input bit blz,
                                             input int i);
      longint unsigned p, lim;
      p = 1;
      lim = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      for (int k = 0; k < N; k++) lim = lim * 10;
      if (dec) begin
         if (v >= lim) return 8'h40;
         if (blz && i > 0 && v < p) return 8'h00;
         return SEGTAB[int'((v / p) % 10)];
      end
      if ((v >> (4 * N)) != 0) return 8'h40;
      return SEGTAB[int'((v >> (4 * i)) & 15)];
   endfunction

   // Per-cycle compare: scan position and shown segment against the model.
   always @(negedge clk1M8) begin
      if (!rst_n) begin
         edges = 0;
         pend = 0;
         stale_cnt = 0;
         for (int i = 0; i < N; i++) exp_disp[i] = 8'h00;
      end else begin
         edges++;
         stale_cnt++;
         if (pend > 0) begin
            pend--;
            if (pend == 0)
               for (int i = 0; i < N; i++) exp_disp[i] = model_code(sent_val, sent_dec, sent_blz, i);
         end
         if (frame_valid) begin
            fv_cnt++;
            pend = DW + 8;
            stale_cnt = 0;
         end
         if (frame_err) fe_cnt++;
         if (stale_cnt == STALE + 4 && pend == 0)
            for (int i = 0; i < N; i++) exp_disp[i] = 8'h00;
         if (pend == 0 && !(stale_cnt >= STALE - 4 && stale_cnt < STALE + 4)) begin
            exp_idx = (edges / SD) % N;
            total++;
            if (dig_sel !== (N'(1) << exp_idx) || seg !== exp_disp[exp_idx]) begin
               bad++;
               $display("FAIL scan t=%0t dig_sel=%b seg=%h required dig_sel=%b seg=%h", $time,
                        dig_sel, seg, N'(1) << exp_idx, exp_disp[exp_idx]);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit good_stop);
      serial = 1'b0;
      repeat (BD) @(negedge clk1M8);
      for (int i = 0; i < 8; i++) begin
         serial = b[i];
         repeat (BD) @(negedge clk1M8);
      end
      serial = good_stop;
      repeat (BD) @(negedge clk1M8);
      serial = 1'b1;
   endtask

   task automatic send_frame(input logic [DW-1:0] v, input bit dec, input bit blz,
                             input bit bad_stop, input int gap);
      mode_dec = dec;
      blank_lz = blz;
      sent_val = v;
      sent_dec = dec;
      sent_blz = blz;
      send_byte(v[7:0], 1'b1);
      repeat (gap) @(negedge clk1M8);
      send_byte(v[15:8], !bad_stop);
      repeat (DW + 40) @(negedge clk1M8);
      if (bad_stop) exp_fe++;
      else          exp_fv++;
   endtask

   task automatic check_counts(input string name);
      total++;
      if (fv_cnt != exp_fv) begin
         bad++;
         $display("FAIL %s frame_valid pulses=%0d required=%0d", name, fv_cnt, exp_fv);
      end
      total++;
      if (fe_cnt != exp_fe) begin
         bad++;
         $display("FAIL %s frame_err pulses=%0d required=%0d", name, fe_cnt, exp_fe);
      end
   endtask

   // lits packs digits 3..0 as {d3,d2,d1,d0}.
   task automatic check_digits(input string name, input logic [31:0] lits);
      int w;
      for (int d = 0; d < N; d++) begin
         w = 0;
         while (dig_sel !== (N'(1) << d) && w < 2 * N * SD) begin
            @(negedge clk1M8);
            w++;
         end
         total++;
         if (dig_sel !== (N'(1) << d)) begin
            bad++;
            $display("FAIL %s digit %0d never selected dig_sel=%b", name, d, dig_sel);
         end else if (seg !== lits[8*d +: 8]) begin
            bad++;
            $display("FAIL %s digit %0d seg=%h required=%h", name, d, seg, lits[8*d +: 8]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if (seg !== 8'h00 || dig_sel !== N'(1) || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL %s seg=%h dig_sel=%b fv=%b fe=%b required seg=00 dig_sel=0001 fv=0 fe=0",
                  name, seg, dig_sel, frame_valid, frame_err);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] v;
      bit            dec, blz, bstop;
      int            base;

      repeat (5) @(negedge clk1M8);
      check_reset_outputs("reset");
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk1M8);

      send_frame(16'h1234, 1, 0, 0, 5);
      check_counts("dec_1234");
      check_digits("dec_1234", 32'h667D7D3F);

      send_frame(16'h1234, 0, 0, 0, 40);
      check_counts("hex_1234");
      check_digits("hex_1234", 32'h065B4F66);

      send_frame(16'hFFFF, 1, 0, 0, 0);
      check_counts("dec_ovf");
      check_digits("dec_ovf", 32'h40404040);

      send_frame(16'h0007, 1, 1, 0, 17);
      check_counts("dec_lz");
      check_digits("dec_lz", 32'h00000007);

      send_frame(16'h1234, 1, 0, 1, 10);
      check_counts("bad_stop");
      check_digits("bad_stop", 32'h00000007);

      send_byte(8'h34, 1'b1);
      repeat (GAP + 100) @(negedge clk1M8);
      exp_fe++;
      check_counts("gap_timeout");
      check_digits("gap_timeout", 32'h00000007);

      for (int k = 0; k < 20; k++) begin
         v     = DW'($urandom);
         if (k % 4 == 0) v = DW'($urandom_range(0, 120));
         dec   = 1'($urandom_range(0, 1));
         blz   = 1'($urandom_range(0, 1));
         bstop = ($urandom_range(0, 5) == 0);
         send_frame(v, dec, blz, bstop, int'($urandom_range(0, 300)));
         check_counts("random");
      end

      send_frame(16'h0042, 0, 0, 0, 3);
      check_counts("hex_0042");
      check_digits("hex_0042", 32'h3F3F665B);
      repeat (STALE + 200) @(negedge clk1M8);
      check_digits("stale", 32'h00000000);

      serial = 1'b0;
      repeat (BD * 3) @(negedge clk1M8);
      #2 rst_n = 1'b0;
      serial = 1'b1;
      repeat (4) @(negedge clk1M8);
      check_reset_outputs("mid_reset");
      #2 rst_n = 1'b1;
      @(negedge clk1M8);
      check_reset_outputs("after_reset");
      base = fv_cnt;
      send_frame(16'h1234, 1, 0, 0, 8);
      total++;
      if (fv_cnt - base != 1) begin
         bad++;
         $display("FAIL reset_frame frame_valid pulses=%0d required=1", fv_cnt - base);
      end
      check_counts("reset_frame");
      check_digits("reset_frame", 32'h667D7D3F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
